data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sig_r_ctrl_data_mem  input  1  load request strobe from control word.
REQ-006 SHALL have port sig_w_ctrl_data_mem  input  1  store request strobe from control word.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port funct3  input  3  RV32I load/store width and signedness.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rdata  output  32  load result, extended to 32 bits.
REQ-011 SHALL have port ready  output  1  one-cycle pulse marking access completion.
REQ-012 SHALL have port busy  output  1  high while an access is in flight.
REQ-013 SHALL have port err  output  1  misalignment flag, qualified by ready.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT_STATES=0.
REQ-015 In IDLE, a request (either strobe high) SHALL be accepted, capturing addr, funct3, wdata and kind; busy rises next cycle.
REQ-016 Both strobes high in the same cycle SHALL be treated as a store; the read is dropped.
REQ-017 Strobes while busy SHALL be ignored, not queued.
REQ-018 ready SHALL pulse high for exactly one cycle, WAIT_STATES+1 cycles after the acceptance edge; busy falls with that cycle.
REQ-019 Store SHALL commit to storage on the RESP-exit edge using byte enables: SB one lane by addr[1:0], SH two lanes by addr[1], SW all four.
REQ-020 Load SHALL select lanes the same way; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; undefined funct3 codes return 0.
REQ-021 rdata SHALL update only when ready is high for a load and hold its value otherwise, including after stores.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
REQ-023 Back-to-back access SHALL be accepted in the cycle after ready (IDLE), giving throughput one access per WAIT_STATES+2 cycles.

Reset
REQ-024 rst_n low SHALL force state IDLE, rdata=0, ready=0, busy=0, err=0 immediately, independent of clk.
REQ-025 Reset during WAIT or RESP SHALL abort the access with no storage write; storage contents are not reset.

Configuration
REQ-026 With DMEM_MISALIGN_TRAP_EN defined: halfword at odd address or word with addr[1:0]!=0 SHALL set err with ready, suppress the write, and leave rdata unchanged.
REQ-027 Without DMEM_MISALIGN_TRAP_EN: err SHALL be tied 0 and offending low address bits SHALL be forced to natural alignment (addr[0]=0 for halfword, addr[1:0]=0 for word).

Structure
REQ-028 Shared package rv32i_pkg SHALL hold funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state typedef.
REQ-029 Storage SHALL be a sub-module dmem_array: synchronous write with 4-bit byte enable, combinational read of one word.

Verification
REQ-030 SW addr 0x10 wdata 0xDEADBEEF, then LW addr 0x10 -> rdata 0xDEADBEEF, ready at acceptance+WAIT_STATES+1.
REQ-031 After REQ-030, LB addr 0x13 -> 0xFFFFFFDE; LBU addr 0x13 -> 0x000000DE; LH addr 0x12 -> 0xFFFFDEAD; LHU addr 0x10 -> 0x0000BEEF.
REQ-032 SB addr 0x11 wdata 0x55 over 0xDEADBEEF, LW 0x10 -> 0xDEAD55EF.
REQ-033 Both strobes high, addr 0x20 wdata 0x1234 -> single ready, word 0x20 becomes 0x00001234, rdata unchanged.
REQ-034 SW 0x21 with macro -> err=1 with ready, no write; without macro -> write lands at 0x20, err=0.
REQ-035 Assert rst_n low mid-WAIT of SW 0x30 -> outputs 0 at once, word 0x30 unchanged, next request served normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I load/store width encodings, alignment helpers and the responder FSM state type.
package rv32i_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == LH) || (f3 == LHU);
  endfunction

  function automatic logic is_word(input logic [2:0] f3);
    return f3 == LW;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return (is_half(f3) && lo[0]) || (is_word(f3) && (lo != 2'b00));
  endfunction

  // Natural alignment of the low address bits for the access width.
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    if (is_word(f3)) return 2'b00;
    if (is_half(f3)) return {lo[1], 1'b0};
    return lo;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide data storage: synchronous byte-enabled write, combinational read of one word.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// Single-port RV32I data memory responder with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses via err instead of force-aligning them.
module data_mem_responder
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_r_ctrl_data_mem,
  input  logic        sig_w_ctrl_data_mem,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e        state_q;
  logic [3:0]    wait_cnt_q;
  logic [AW+1:0] addr_q;
  logic [2:0]    funct3_q;
  logic [31:0]   wdata_q;
  logic          is_store_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          busy_q;

  logic [AW+1:0] addr_cap;
  logic          misalign;
  logic          mem_we;
  logic [3:0]    store_be;
  logic [31:0]   store_data;
  logic [31:0]   mem_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;

  // Address bits above the array are ignored so accesses wrap around.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  assign addr_cap = addr[AW+1:0];
  assign misalign = is_misaligned(funct3_q, addr_q[1:0]);
  assign err      = err_q;
`else
  assign addr_cap = {addr[AW+1:2], align_lo(funct3, addr[1:0])};
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    store_be   = 4'b0000;
    store_data = wdata_q;
    case (funct3_q)
      SB: begin
        store_be   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      SH: begin
        store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      SW: store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: ld_byte = mem_word[7:0];
      2'd1: ld_byte = mem_word[15:8];
      2'd2: ld_byte = mem_word[23:16];
      2'd3: ld_byte = mem_word[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
    load_val = 32'h0;
    case (funct3_q)
      LB:      load_val = {{24{ld_byte[7]}}, ld_byte};
      LH:      load_val = {{16{ld_half[15]}}, ld_half};
      LW:      load_val = mem_word;
      LBU:     load_val = {24'h0, ld_byte};
      LHU:     load_val = {16'h0, ld_half};
      default: load_val = 32'h0;
    endcase
  end

  // Storage is written only on the edge leaving RESP, so a reset mid-access leaves it untouched.
  assign mem_we = (state_q == StResp) && is_store_q && !misalign;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (store_be),
    .index (addr_q[AW+1:2]),
    .wdata (store_data),
    .rdata (mem_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      funct3_q   <= 3'b000;
      wdata_q    <= 32'h0;
      is_store_q <= 1'b0;
      rdata_q    <= 32'h0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (sig_r_ctrl_data_mem || sig_w_ctrl_data_mem) begin
            addr_q     <= addr_cap;
            funct3_q   <= funct3;
            wdata_q    <= wdata;
            // A simultaneous read strobe is dropped in favour of the store.
            is_store_q <= sig_w_ctrl_data_mem;
            busy_q     <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              state_q    <= StWait;
              wait_cnt_q <= 4'(WAIT_STATES - 1);
            end
          end
        end
        StWait: begin
          if (wait_cnt_q == 4'd0) state_q <= StResp;
          else wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
          err_q   <= misalign;
`endif
          if (!is_store_q && !misalign) rdata_q <= load_val;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-addressed reference memory model.
module tb_data_mem_responder;
  import rv32i_pkg::*;

  localparam int unsigned DW = 256;
  localparam int unsigned WS = 1;
  localparam int unsigned NB = DW * 4;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sig_r = 1'b0;
  logic        sig_w = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  logic [7:0]  mem_m [NB];
  logic [31:0] rdata_exp;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(DW),
    .WAIT_STATES(WS)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sig_r_ctrl_data_mem (sig_r),
    .sig_w_ctrl_data_mem (sig_w),
    .addr                (addr),
    .funct3              (funct3),
    .wdata               (wdata),
    .rdata               (rdata),
    .ready               (ready),
    .busy                (busy),
    .err                 (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: little-endian byte memory, address taken modulo the array size.
  task automatic model(input bit store, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, output bit exp_err);
    int unsigned b;
    bit half, word;
    logic [7:0]  bv;
    logic [15:0] hv;
    exp_err = 1'b0;
    b = a % NB;
    half = (f3 == 3'b001) || (f3 == 3'b101);
    word = (f3 == 3'b010);
    if ((half && (b % 2 != 0)) || (word && (b % 4 != 0))) begin
      if (Trap) begin
        exp_err = 1'b1;
        return;
      end
      b = half ? b - (b % 2) : b - (b % 4);
    end
    if (store) begin
      if (f3 == 3'b000) mem_m[b] = wd[7:0];
      if (f3 == 3'b001) begin
        mem_m[b]   = wd[7:0];
        mem_m[b+1] = wd[15:8];
      end
      if (f3 == 3'b010) begin
        for (int k = 0; k < 4; k++) mem_m[b+k] = wd[8*k +: 8];
      end
    end else begin
      bv = mem_m[b];
      hv = {mem_m[b+1], mem_m[b]};
      case (f3)
        3'b000:  rdata_exp = {{24{bv[7]}}, bv};
        3'b001:  rdata_exp = {{16{hv[15]}}, hv};
        3'b010:  rdata_exp = {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
        3'b100:  rdata_exp = {24'h0, bv};
        3'b101:  rdata_exp = {16'h0, hv};
        default: rdata_exp = 32'h0;
      endcase
    end
  endtask

  // One access; optional noise drives strobes while busy, which must be ignored.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [2:0] f3, input logic [31:0] wd, input bit noise);
    bit exp_err;
    int n;
    @(negedge clk);
    sig_r = rd;
    sig_w = wr;
    addr = a;
    funct3 = f3;
    wdata = wd;
    model(wr, a, f3, wd, exp_err);
    @(posedge clk);
    #1;
    check_eq("ready_pulse", {31'h0, ready}, 32'h0);
    check_eq("busy_rise", {31'h0, busy}, 32'h1);
    if (noise) begin
      sig_r = 1'b1;
      sig_w = 1'($urandom % 2);
      addr = $urandom;
      funct3 = 3'($urandom_range(0, 2));
      wdata = $urandom;
    end else begin
      sig_r = 1'b0;
      sig_w = 1'b0;
    end
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
      check_eq("busy_hold", {31'h0, busy}, 32'h1);
    end
    sig_r = 1'b0;
    sig_w = 1'b0;
    check_eq("latency", n, WS + 1);
    check_eq("busy_fall", {31'h0, busy}, 32'h0);
    check_eq("err", {31'h0, err}, {31'h0, exp_err});
    check_eq("rdata", rdata, rdata_exp);
  endtask

  initial begin
    bit k_rd, k_wr;
    int kind;
    logic [2:0] f3;
    rdata_exp = 32'h0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_ready", {31'h0, ready}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(DW); i++) do_access(1'b0, 1'b1, 32'(i * 4), SW, $urandom, 1'b0);

    do_access(1'b0, 1'b1, 32'h10, SW, 32'hDEADBEEF, 1'b0);
    do_access(1'b1, 1'b0, 32'h10, LW, 32'h0, 1'b0);
    check_eq("lw_10", rdata, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h13, LB, 32'h0, 1'b0);
    check_eq("lb_13", rdata, 32'hFFFFFFDE);
    do_access(1'b1, 1'b0, 32'h13, LBU, 32'h0, 1'b0);
    check_eq("lbu_13", rdata, 32'h000000DE);
    do_access(1'b1, 1'b0, 32'h12, LH, 32'h0, 1'b0);
    check_eq("lh_12", rdata, 32'hFFFFDEAD);
    do_access(1'b1, 1'b0, 32'h10, LHU, 32'h0, 1'b0);
    check_eq("lhu_10", rdata, 32'h0000BEEF);
    do_access(1'b0, 1'b1, 32'h11, SB, 32'h55, 1'b0);
    do_access(1'b1, 1'b0, 32'h10, LW, 32'h0, 1'b0);
    check_eq("sb_merge", rdata, 32'hDEAD55EF);

    do_access(1'b1, 1'b1, 32'h20, SW, 32'h1234, 1'b0);
    check_eq("both_rdata_hold", rdata, 32'hDEAD55EF);
    do_access(1'b1, 1'b0, 32'h20, LW, 32'h0, 1'b0);
    check_eq("both_word", rdata, 32'h00001234);

    do_access(1'b0, 1'b1, 32'h21, SW, 32'hCAFEF00D, 1'b0);
    do_access(1'b1, 1'b0, 32'h20, LW, 32'h0, 1'b0);
    check_eq("sw_21", rdata, Trap ? 32'h00001234 : 32'hCAFEF00D);

    do_access(1'b0, 1'b1, 32'h40, SW, 32'h600DF00D, 1'b1);
    do_access(1'b1, 1'b0, 32'h40, LW, 32'h0, 1'b1);

    // Reset in the middle of a store's wait state.
    @(negedge clk);
    sig_w = 1'b1;
    addr = 32'h30;
    funct3 = SW;
    wdata = 32'hA5A50F0F;
    @(posedge clk);
    #1;
    sig_w = 1'b0;
    check_eq("abort_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_rdata", rdata, 32'h0);
    check_eq("abort_ready", {31'h0, ready}, 32'h0);
    check_eq("abort_busy0", {31'h0, busy}, 32'h0);
    check_eq("abort_err", {31'h0, err}, 32'h0);
    rdata_exp = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 32'h30, LW, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      k_rd = (kind != 1);
      k_wr = (kind != 0);
      f3 = k_wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      do_access(k_rd, k_wr, $urandom, f3, $urandom, ($urandom % 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
